// File: rtl/led_seq_pkg.sv
// Shared encodings and seed helpers for the LED pattern sequencer.
package led_seq_pkg;

  localparam int MAX_LED = 32;

  typedef enum logic [1:0] {
    MODE_SHL   = 2'd0,
    MODE_SHR   = 2'd1,
    MODE_PING  = 2'd2,
    MODE_FLASH = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHL   = 3'd1,
    ST_SHR   = 3'd2,
    ST_PING  = 3'd3,
    ST_FLASH = 3'd4
  } state_e;

  function automatic logic [MAX_LED-1:0] seed_low();
    return {{(MAX_LED-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [MAX_LED-1:0] seed_msb(input int nb);
    return seed_low() << (nb - 1);
  endfunction

  // Alternating 0101... pattern with the LSB set.
  function automatic logic [MAX_LED-1:0] seed_alt();
    logic [MAX_LED-1:0] s;
    s = '0;
    for (int i = 0; i < MAX_LED; i += 2) begin
      s = s | (seed_low() << i);
    end
    return s;
  endfunction

  // Active states follow the mode encoding, offset past IDLE.
  function automatic state_e mode_to_state(input mode_e m);
    return state_e'({1'b0, m} + 3'd1);
  endfunction

endpackage

// File: rtl/led_seq_ctrl_sw_sync.sv
// Switch synchroniser with optional debounce (LED_SEQ_DEBOUNCE_EN).
module sw_sync
  import led_seq_pkg::*;
#(
  parameter int W           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 16
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic [W-1:0] sw_async,
  output logic [W-1:0] sw_s
);

  logic [SYNC_STAGES-1:0][W-1:0] sync_r;

  // Metastability chain; stage 0 captures the raw switches.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], sw_async};
    end
  end

`ifdef LED_SEQ_DEBOUNCE_EN
  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

  logic [W-1:0] deb_r;

  for (genvar b = 0; b < W; b++) begin : g_deb
    logic          prev_r;
    logic [CW-1:0] cnt_r;

    // Accept a bit only after DEB_CYCLES identical samples in a row.
    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        prev_r   <= 1'b0;
        cnt_r    <= '0;
        deb_r[b] <= 1'b0;
      end else if (sync_r[SYNC_STAGES-1][b] != prev_r) begin
        prev_r <= sync_r[SYNC_STAGES-1][b];
        cnt_r  <= '0;
      end else if (cnt_r != CW'(DEB_CYCLES - 2)) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        deb_r[b] <= prev_r;
      end
    end
  end

  assign sw_s = deb_r;
`else
  assign sw_s = sync_r[SYNC_STAGES-1];

  // DEB_CYCLES is only consumed by the debounce build.
  if (DEB_CYCLES < 2) begin : g_deb_unused
  end
`endif

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer top. Optional switch debounce via LED_SEQ_DEBOUNCE_EN.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int NB_LED      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 16
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic              i_tick,
  input  logic [3:0]        i_sw,
  output logic [NB_LED-1:0] o_led,
  output logic [NB_LED-1:0] o_led_b,
  output logic [NB_LED-1:0] o_led_g,
  output logic [2:0]        o_state,
  output logic              o_mode_chg
);

  localparam logic [MAX_LED-1:0] SEED_LOW_F = seed_low();
  localparam logic [MAX_LED-1:0] SEED_MSB_F = seed_msb(NB_LED);
  localparam logic [MAX_LED-1:0] SEED_ALT_F = seed_alt();
  localparam logic [NB_LED-1:0]  SEED_LOW   = SEED_LOW_F[NB_LED-1:0];
  localparam logic [NB_LED-1:0]  SEED_MSB   = SEED_MSB_F[NB_LED-1:0];
  localparam logic [NB_LED-1:0]  SEED_ALT   = SEED_ALT_F[NB_LED-1:0];

  logic [3:0]        sw_s;
  logic              run_s;
  mode_e             req_mode_s;
  state_e            state_r, state_nxt_s;
  mode_e             mode_r, mode_nxt_s;
  logic [NB_LED-1:0] pattern_r, pattern_nxt_s, seed_s, step_s;
  logic              dir_r, dir_nxt_s, step_dir_s;
  logic              load_s, adv_s, chg_nxt_s;
  logic [NB_LED-1:0] led_b_r, led_g_r;
  logic              chg_r;

  sw_sync #(
    .W           (4),
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_CYCLES  (DEB_CYCLES)
  ) u_sw_sync (
    .clock    (clock),
    .rst_n    (i_reset),
    .sw_async (i_sw),
    .sw_s     (sw_s)
  );

  assign run_s      = sw_s[0];
  assign req_mode_s = mode_e'(sw_s[2:1]);

  // State, pattern and registered outputs.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_r   <= ST_IDLE;
      mode_r    <= MODE_SHL;
      pattern_r <= '0;
      dir_r     <= 1'b1;
      led_b_r   <= '0;
      led_g_r   <= '0;
      chg_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      mode_r    <= mode_nxt_s;
      pattern_r <= pattern_nxt_s;
      dir_r     <= dir_nxt_s;
      led_b_r   <= sw_s[3] ? pattern_nxt_s : '0;
      led_g_r   <= sw_s[3] ? '0 : pattern_nxt_s;
      chg_r     <= chg_nxt_s;
    end
  end

  // Next state; dropping run always wins over a coincident tick.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_tick && run_s) state_nxt_s = mode_to_state(req_mode_s);
        else                 state_nxt_s = ST_IDLE;
      end
      ST_SHL, ST_SHR, ST_PING, ST_FLASH: begin
        if (!run_s)      state_nxt_s = ST_IDLE;
        else if (i_tick) state_nxt_s = mode_to_state(req_mode_s);
        else             state_nxt_s = state_r;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Seed for the requested mode and one step of the current mode.
  always_comb begin
    case (req_mode_s)
      MODE_SHL, MODE_PING: seed_s = SEED_LOW;
      MODE_SHR:            seed_s = SEED_MSB;
      MODE_FLASH:          seed_s = SEED_ALT;
      default:             seed_s = SEED_LOW;
    endcase
    step_dir_s = dir_r;
    case (mode_r)
      MODE_SHL:   step_s = {pattern_r[NB_LED-2:0], pattern_r[NB_LED-1]};
      MODE_SHR:   step_s = {pattern_r[0], pattern_r[NB_LED-1:1]};
      MODE_PING: begin
        if (dir_r) begin
          step_s     = {pattern_r[NB_LED-2:0], 1'b0};
          step_dir_s = ~step_s[NB_LED-1];
        end else begin
          step_s     = {1'b0, pattern_r[NB_LED-1:1]};
          step_dir_s = step_s[0];
        end
      end
      MODE_FLASH: step_s = ~pattern_r;
      default:    step_s = pattern_r;
    endcase
  end

  // Output decode: seed on start/mode change, otherwise advance on tick.
  always_comb begin
    load_s        = 1'b0;
    adv_s         = 1'b0;
    pattern_nxt_s = pattern_r;
    dir_nxt_s     = dir_r;
    mode_nxt_s    = mode_r;
    chg_nxt_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_tick && run_s) begin
          if (pattern_r == '0 || req_mode_s != mode_r) load_s = 1'b1;
          else                                         adv_s  = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      ST_SHL, ST_SHR, ST_PING, ST_FLASH: begin
        if (i_tick && run_s) begin
          if (req_mode_s != mode_r) load_s = 1'b1;
          else                      adv_s  = 1'b1;
        end else begin
          adv_s = 1'b0;
        end
      end
      default: begin
        load_s = 1'b0;
        adv_s  = 1'b0;
      end
    endcase
    if (load_s) begin
      pattern_nxt_s = seed_s;
      dir_nxt_s     = 1'b1;
      mode_nxt_s    = req_mode_s;
      chg_nxt_s     = (req_mode_s != mode_r);
    end else if (adv_s) begin
      pattern_nxt_s = step_s;
      dir_nxt_s     = step_dir_s;
    end else begin
      chg_nxt_s = 1'b0;
    end
  end

  assign o_led      = pattern_r;
  assign o_led_b    = led_b_r;
  assign o_led_g    = led_g_r;
  assign o_state    = state_r;
  assign o_mode_chg = chg_r;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl (default build, no debounce).
module tb_led_seq_ctrl;

  localparam int NB = 4;

  logic          clock;
  logic          i_reset;
  logic          i_tick;
  logic [3:0]    i_sw;
  logic [NB-1:0] o_led, o_led_b, o_led_g;
  logic [2:0]    o_state;
  logic          o_mode_chg;

  int n_pass  = 0;
  int n_total = 0;

  led_seq_ctrl #(.NB_LED(NB), .SYNC_STAGES(2), .DEB_CYCLES(16)) dut (
    .clock      (clock),
    .i_reset    (i_reset),
    .i_tick     (i_tick),
    .i_sw       (i_sw),
    .o_led      (o_led),
    .o_led_b    (o_led_b),
    .o_led_g    (o_led_g),
    .o_state    (o_state),
    .o_mode_chg (o_mode_chg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: positions/phase instead of bit vectors.
  logic [3:0]    d1, d2, sw_eff;
  bit            m_started, m_active, m_phase, m_chg;
  int            m_last, m_pos, m_dir;
  logic [NB-1:0] exp_led, exp_b, exp_g;
  logic [2:0]    exp_state;
  logic          exp_chg;

  function automatic logic [NB-1:0] alt_pat();
    logic [NB-1:0] a;
    a = '0;
    for (int i = 0; i < NB; i += 2) a[i] = 1'b1;
    return a;
  endfunction

  task model_seed(input int m);
    m_last = m;
    m_phase = 1'b0;
    m_dir = 1;
    if (m == 1) m_pos = NB - 1;
    else        m_pos = 0;
    m_started = 1'b1;
  endtask

  task model_step();
    case (m_last)
      0: m_pos = (m_pos + 1) % NB;
      1: m_pos = (m_pos + NB - 1) % NB;
      2: begin
        m_pos = m_pos + m_dir;
        if (m_pos == NB - 1) m_dir = -1;
        if (m_pos == 0)      m_dir = 1;
      end
      default: m_phase = ~m_phase;
    endcase
  endtask

  always @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      d1 = '0; d2 = '0;
      m_started = 0; m_active = 0; m_phase = 0;
      m_last = 0; m_pos = 0; m_dir = 1;
      exp_led = '0; exp_b = '0; exp_g = '0; exp_state = '0; exp_chg = 1'b0;
    end else begin
      sw_eff = d2; d2 = d1; d1 = i_sw;
      m_chg = 1'b0;
      if (!m_active) begin
        if (i_tick && sw_eff[0]) begin
          if (!m_started || int'(sw_eff[2:1]) != m_last) begin
            m_chg = (int'(sw_eff[2:1]) != m_last);
            model_seed(int'(sw_eff[2:1]));
          end else begin
            model_step();
          end
          m_active = 1'b1;
        end
      end else if (!sw_eff[0]) begin
        m_active = 1'b0;
      end else if (i_tick) begin
        if (int'(sw_eff[2:1]) != m_last) begin
          m_chg = 1'b1;
          model_seed(int'(sw_eff[2:1]));
        end else begin
          model_step();
        end
      end
      if (!m_started)       exp_led = '0;
      else if (m_last == 3) exp_led = m_phase ? ~alt_pat() : alt_pat();
      else                  exp_led = NB'(1) << m_pos;
      exp_b     = sw_eff[3] ? exp_led : '0;
      exp_g     = sw_eff[3] ? '0 : exp_led;
      exp_state = m_active ? 3'(m_last + 1) : 3'd0;
      exp_chg   = m_chg;
    end
  end

  // Apply inputs for one rising edge; returns at the following falling edge.
  task automatic cyc(input logic [3:0] sw, input logic tk);
    i_sw   = sw;
    i_tick = tk;
    @(negedge clock);
    i_tick = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    n_total++; if (o_led !== 4'b0000) $display("FAIL reset_led: got %b want 0000", o_led); else n_pass++;
    n_total++; if (o_led_b !== 4'b0000 || o_led_g !== 4'b0000) $display("FAIL reset_bg: got %b/%b want 0000/0000", o_led_b, o_led_g); else n_pass++;
    n_total++; if (o_state !== 3'd0 || o_mode_chg !== 1'b0) $display("FAIL reset_state: got %0d/%b want 0/0", o_state, o_mode_chg); else n_pass++;
    i_reset = 1'b1;
    cyc(4'b0000, 1'b1);
    n_total++; if (o_state !== exp_state) $display("FAIL reset_idle_tick: got %0d want %0d", o_state, exp_state); else n_pass++;
  endtask

  task automatic test_shl();
    logic [3:0] want [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int k = 0; k < 5; k++) begin
      repeat (9) cyc(4'b0001, 1'b0);
      cyc(4'b0001, 1'b1);
      n_total++; if (o_led !== want[k]) $display("FAIL shl_led[%0d]: got %b want %b", k, o_led, want[k]); else n_pass++;
      n_total++; if (o_led_g !== want[k] || o_led_b !== 4'b0000) $display("FAIL shl_colour[%0d]: got g=%b b=%b want g=%b b=0000", k, o_led_g, o_led_b, want[k]); else n_pass++;
    end
  endtask

  task automatic test_ping();
    logic [3:0] want [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    for (int k = 0; k < 8; k++) begin
      repeat (3) cyc(4'b0101, 1'b0);
      cyc(4'b0101, 1'b1);
      n_total++; if (o_led !== want[k]) $display("FAIL ping_led[%0d]: got %b want %b", k, o_led, want[k]); else n_pass++;
      n_total++; if (o_mode_chg !== exp_chg || o_state !== exp_state) $display("FAIL ping_ctl[%0d]: got chg=%b st=%0d want chg=%b st=%0d", k, o_mode_chg, o_state, exp_chg, exp_state); else n_pass++;
    end
  endtask

  task automatic test_flash_midway();
    for (int k = 0; k < 3; k++) begin
      repeat (3) cyc(4'b0001, 1'b0);
      cyc(4'b0001, 1'b1);
    end
    n_total++; if (o_led !== 4'b0100) $display("FAIL flash_pre: got %b want 0100", o_led); else n_pass++;
    repeat (5) cyc(4'b0111, 1'b0);
    n_total++; if (o_led !== 4'b0100 || o_state !== 3'd1) $display("FAIL flash_between: got %b st=%0d want 0100 st=1", o_led, o_state); else n_pass++;
    cyc(4'b0111, 1'b1);
    n_total++; if (o_led !== 4'b0101 || o_mode_chg !== 1'b1 || o_state !== 3'd4) $display("FAIL flash_load: got %b chg=%b st=%0d want 0101 chg=1 st=4", o_led, o_mode_chg, o_state); else n_pass++;
    cyc(4'b0111, 1'b0);
    n_total++; if (o_mode_chg !== 1'b0) $display("FAIL flash_chg_pulse: got %b want 0", o_mode_chg); else n_pass++;
    repeat (2) cyc(4'b0111, 1'b0);
    cyc(4'b0111, 1'b1);
    n_total++; if (o_led !== 4'b1010) $display("FAIL flash_step: got %b want 1010", o_led); else n_pass++;
  endtask

  task automatic test_stop_resume();
    for (int k = 0; k < 2; k++) begin
      repeat (3) cyc(4'b0001, 1'b0);
      cyc(4'b0001, 1'b1);
    end
    n_total++; if (o_led !== 4'b0010) $display("FAIL stop_pre: got %b want 0010", o_led); else n_pass++;
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b1);
    n_total++; if (o_led !== 4'b0010 || o_state !== 3'd0) $display("FAIL stop_tick: got %b st=%0d want 0010 st=0", o_led, o_state); else n_pass++;
    repeat (4) cyc(4'b0001, 1'b0);
    n_total++; if (o_led !== 4'b0010 || o_state !== 3'd0) $display("FAIL stop_hold: got %b st=%0d want 0010 st=0", o_led, o_state); else n_pass++;
    cyc(4'b0001, 1'b1);
    n_total++; if (o_led !== 4'b0100 || o_state !== 3'd1) $display("FAIL resume: got %b st=%0d want 0100 st=1", o_led, o_state); else n_pass++;
  endtask

  task automatic test_colour_and_reset();
    cyc(4'b1001, 1'b0);
    cyc(4'b1001, 1'b0);
    n_total++; if (o_led_b !== 4'b0000 || o_led_g !== 4'b0100) $display("FAIL colour_early: got b=%b g=%b want b=0000 g=0100", o_led_b, o_led_g); else n_pass++;
    cyc(4'b1001, 1'b0);
    n_total++; if (o_led_b !== 4'b0100 || o_led_g !== 4'b0000) $display("FAIL colour_blue: got b=%b g=%b want b=0100 g=0000", o_led_b, o_led_g); else n_pass++;
    #2 i_reset = 1'b0;
    #1;
    n_total++; if (o_led !== 4'b0000 || o_led_b !== 4'b0000 || o_state !== 3'd0) $display("FAIL async_reset: got led=%b b=%b st=%0d want 0000 0000 0", o_led, o_led_b, o_state); else n_pass++;
    @(negedge clock);
    i_reset = 1'b1;
  endtask

  task automatic test_back_to_back();
    repeat (3) cyc(4'b0011, 1'b0);
    for (int k = 0; k < 8; k++) begin
      cyc(4'b0011, 1'b1);
      if (k == 0) begin
        n_total++; if (o_led !== 4'b1000) $display("FAIL b2b_seed: got %b want 1000", o_led); else n_pass++;
      end
      n_total++; if (o_led !== exp_led || o_state !== exp_state || o_mode_chg !== exp_chg) $display("FAIL b2b[%0d]: got %b st=%0d chg=%b want %b st=%0d chg=%b", k, o_led, o_state, o_mode_chg, exp_led, exp_state, exp_chg); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [3:0] sw;
    sw = 4'b0001;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        sw = 4'($urandom);
        if ($urandom_range(0, 3) != 0) sw[0] = 1'b1;
      end
      cyc(sw, 1'($urandom_range(0, 2) == 0));
      n_total++; if (o_led !== exp_led) $display("FAIL rnd_led[%0d]: got %b want %b", k, o_led, exp_led); else n_pass++;
      n_total++; if (o_led_b !== exp_b || o_led_g !== exp_g) $display("FAIL rnd_bg[%0d]: got %b/%b want %b/%b", k, o_led_b, o_led_g, exp_b, exp_g); else n_pass++;
      n_total++; if (o_state !== exp_state || o_mode_chg !== exp_chg) $display("FAIL rnd_ctl[%0d]: got st=%0d chg=%b want st=%0d chg=%b", k, o_state, o_mode_chg, exp_state, exp_chg); else n_pass++;
    end
  endtask

  initial begin
    i_reset = 1'b0;
    i_sw    = 4'b0000;
    i_tick  = 1'b0;
    test_reset();
    test_shl();
    test_ping();
    test_flash_midway();
    test_stop_resume();
    test_colour_and_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
